vga_layered_timing_pipe: RTL

- Parametrised successor to the fixed 640x480 VGA controller.
- Generates h/v timing from parameters, linear framebuffer address, and pixel x/y.
- Merges the background pixel from a fixed-latency memory with LAYERS priority overlay channels (the successor to the 2-bit colour select).
- Aligns sync/blank with colour through a PIPE-deep delay line.
- Sits between the game-logic overlay modules and the VGA DAC pins.

---
 rtl/vga_layered_timing_pipe_if.sv | 33 +++
 rtl/vga_layered_timing_pipe.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/vga_layered_timing_pipe_if.sv
// Signal bundle between the VGA timing pipe, its framebuffer memory,
// the overlay sources and the DAC pins.
interface vga_layered_timing_pipe_if #(
    parameter int ADDR_W = 19,
    parameter int LAYERS = 2
);
    logic [ADDR_W-1:0]    ADDR;
    logic [9:0]           x_pos;
    logic [9:0]           y_pos;
    logic [23:0]          bg_bgr;
    logic [LAYERS-1:0]    layer_hit;
    logic [24*LAYERS-1:0] layer_bgr;
    logic                 frame_start;
    logic [15:0]          frame_count;
    logic                 oHS;
    logic                 oVS;
    logic                 oBLANK_n;
    logic [7:0]           b_data;
    logic [7:0]           g_data;
    logic [7:0]           r_data;

    modport master (
        output ADDR, x_pos, y_pos, frame_start, frame_count,
               oHS, oVS, oBLANK_n, b_data, g_data, r_data,
        input  bg_bgr, layer_hit, layer_bgr
    );

    modport slave (
        input  ADDR, x_pos, y_pos, frame_start, frame_count,
               oHS, oVS, oBLANK_n, b_data, g_data, r_data,
        output bg_bgr, layer_hit, layer_bgr
    );
endinterface

// File: rtl/vga_layered_timing_pipe.sv
// Parametrised VGA timing generator with linear framebuffer addressing,
// priority overlay merge and a sync/blank delay line matched to the
// background memory latency.
module vga_layered_timing_pipe #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int ADDR_W   = 19,
    parameter int LAYERS   = 2,
    parameter int PIPE     = 2
) (
    input logic iVGA_CLK,
    input logic reset,
    vga_layered_timing_pipe_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [15:0] H_ACT_END  = 16'(H_ACTIVE);
    localparam logic [15:0] H_SYNC_BEG = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] H_SYNC_END = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] H_LAST     = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_ACT_END  = 16'(V_ACTIVE);
    localparam logic [15:0] V_SYNC_BEG = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] V_SYNC_END = 16'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [15:0] V_LAST     = 16'(V_TOTAL - 1);

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        blank_n;
        logic        ovl_valid;
        logic [23:0] ovl_bgr;
    } stage_t;

    // A flushed stage: sync deasserted, blanked, no overlay.
    localparam stage_t IDLE_STAGE = {~HS_POL, ~VS_POL, 1'b0, 1'b0, 24'd0};

    logic [15:0]       h_cnt;
    logic [15:0]       v_cnt;
    logic [ADDR_W-1:0] addr_cnt;
    logic [15:0]       frame_cnt;
    logic              h_last;
    logic              frame_last;
    logic              active;
    logic              hs_now;
    logic              vs_now;
    logic              sel_valid;
    logic [23:0]       sel_bgr;
    logic              ovl_hit;
    stage_t            stage_now;
    stage_t            delay_line [PIPE];
    stage_t            dl_out;
    logic              out_hs;
    logic              out_vs;
    logic              out_blank_n;
    logic [23:0]       out_bgr;

    // Decode region membership and sync levels from the raw counters.
    always_comb begin
        h_last     = (h_cnt == H_LAST);
        frame_last = h_last && (v_cnt == V_LAST);
        active     = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
        hs_now     = ((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END)) ? HS_POL : ~HS_POL;
        vs_now     = ((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END)) ? VS_POL : ~VS_POL;
    end

    // Horizontal counter wraps every line and advances the line counter.
    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset) begin
            h_cnt <= 16'd0;
            v_cnt <= 16'd0;
        end else if (h_last) begin
            h_cnt <= 16'd0;
            v_cnt <= (v_cnt == V_LAST) ? 16'd0 : v_cnt + 16'd1;
        end else begin
            h_cnt <= h_cnt + 16'd1;
        end
    end

    // Linear address advances only across visible pixels, so no multiply is needed.
    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset) begin
            addr_cnt <= '0;
        end else if (frame_last) begin
            addr_cnt <= '0;
        end else if (active) begin
            addr_cnt <= addr_cnt + 1'b1;
        end
    end

    // Completed-frame counter, bumped on the final clock of every frame.
    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset) begin
            frame_cnt <= 16'd0;
        end else if (frame_last) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    // Pick the lowest-indexed layer that claims the current pixel.
    always_comb begin
        sel_valid = 1'b0;
        sel_bgr   = 24'd0;
        for (int k = LAYERS - 1; k >= 0; k--) begin
            if (bus.layer_hit[k]) begin
                sel_valid = 1'b1;
                sel_bgr   = bus.layer_bgr[24*k +: 24];
            end
        end
    end

    assign ovl_hit   = active && sel_valid;
    assign stage_now = {hs_now, vs_now, active, ovl_hit, ovl_hit ? sel_bgr : 24'd0};
    assign dl_out    = delay_line[PIPE-1];

    // Delay line that waits out the background memory latency.
    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PIPE; i++) begin
                delay_line[i] <= IDLE_STAGE;
            end
        end else begin
            delay_line[0] <= stage_now;
            for (int i = 1; i < PIPE; i++) begin
                delay_line[i] <= delay_line[i-1];
            end
        end
    end

    // Final pin register: blanking forces black, overlay beats background.
    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset) begin
            out_hs      <= ~HS_POL;
            out_vs      <= ~VS_POL;
            out_blank_n <= 1'b0;
            out_bgr     <= 24'd0;
        end else begin
            out_hs      <= dl_out.hs;
            out_vs      <= dl_out.vs;
            out_blank_n <= dl_out.blank_n;
            if (!dl_out.blank_n) begin
                out_bgr <= 24'd0;
            end else if (dl_out.ovl_valid) begin
                out_bgr <= dl_out.ovl_bgr;
            end else begin
                out_bgr <= bus.bg_bgr;
            end
        end
    end

    assign bus.ADDR        = addr_cnt;
    assign bus.x_pos       = h_cnt[9:0];
    assign bus.y_pos       = v_cnt[9:0];
    assign bus.frame_start = (h_cnt == 16'd0) && (v_cnt == 16'd0);
    assign bus.frame_count = frame_cnt;
    assign bus.oHS         = out_hs;
    assign bus.oVS         = out_vs;
    assign bus.oBLANK_n    = out_blank_n;
    assign bus.b_data      = out_bgr[23:16];
    assign bus.g_data      = out_bgr[15:8];
    assign bus.r_data      = out_bgr[7:0];
endmodule
